// File: rtl/fp_cfg_pkg.sv
// Shared floating-point configuration: default field widths, the all-ones exponent
// and the component class encodings used by the power-of-two scaler.
package fp_cfg_pkg;

   localparam int DEF_EXP_W = 8;
   localparam int DEF_MAN_W = 23;

   function automatic int exp_all_ones(input int w);
      return (1 << w) - 1;
   endfunction

   localparam int EXP_MAX = exp_all_ones(DEF_EXP_W);

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_NORM = 2'd1,
      CLS_SPEC = 2'd2
   } fp_cls_e;

endpackage

// File: rtl/fp_pow2_lane.sv
// Combinational per-component logic: classify an exponent and form the shifted
// exponent sum, and pack a registered component into its scaled result.
module fp_pow2_lane
   import fp_cfg_pkg::*;
#(
   parameter int EXP_W   = DEF_EXP_W,
   parameter int MAN_W   = DEF_MAN_W,
   parameter int SHIFT_W = 5
)
(
   input  logic                       [EXP_W-1:0]   exp_field,
   input  logic signed                [SHIFT_W-1:0] shift,
   output fp_cls_e                                  cls,
   output logic signed                [EXP_W+1:0]   e_sum,
   input  logic                                     reg_sign,
   input  logic                       [EXP_W-1:0]   reg_exp,
   input  logic                       [MAN_W-1:0]   reg_man,
   input  fp_cls_e                                  reg_cls,
   input  logic signed                [EXP_W+1:0]   reg_e_sum,
   output logic                       [EXP_W+MAN_W:0] result,
   output logic                                     ovf,
   output logic                                     unf
);

   localparam int ESUM_W = EXP_W + 2;
   localparam logic signed [ESUM_W-1:0] E_MAX = ESUM_W'(exp_all_ones(EXP_W));

   always_comb begin
      cls   = CLS_NORM;
      e_sum = $signed({2'b00, exp_field}) + ESUM_W'(shift);
      if (exp_field == '0) begin
         cls = CLS_ZERO;
      end else if (exp_field == '1) begin
         cls = CLS_SPEC;
      end
   end

   // Zero class also swallows denormals; no denormal results are ever produced.
   always_comb begin
      result = {reg_sign, reg_exp, reg_man};
      ovf    = 1'b0;
      unf    = 1'b0;
      case (reg_cls)
         CLS_ZERO: result = {reg_sign, {(EXP_W+MAN_W){1'b0}}};
         CLS_SPEC: result = {reg_sign, reg_exp, reg_man};
         default: begin
            if (reg_e_sum >= E_MAX) begin
               result = {reg_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               ovf    = 1'b1;
            end else if (reg_e_sum <= 0) begin
               result = {reg_sign, {(EXP_W+MAN_W){1'b0}}};
               unf    = 1'b1;
            end else begin
               result = {reg_sign, reg_e_sum[EXP_W-1:0], reg_man};
            end
         end
      endcase
   end

endmodule

// File: rtl/cplx_fp_pow2_scale.sv
// Two-stage valid/ready complex scaler: multiplies both IEEE-754 components by
// 2^shift through exponent arithmetic, with sticky overflow/underflow flags.
module cplx_fp_pow2_scale
   import fp_cfg_pkg::*;
#(
   parameter int EXP_W   = DEF_EXP_W,
   parameter int MAN_W   = DEF_MAN_W,
   parameter int SHIFT_W = 5,
   localparam int FP_W   = 1 + EXP_W + MAN_W
)
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [FP_W-1:0]           in_re,
   input  logic [FP_W-1:0]           in_img,
   input  logic signed [SHIFT_W-1:0] in_shift,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [FP_W-1:0]           out_re,
   output logic [FP_W-1:0]           out_img,
   output logic                      ovf_flag,
   output logic                      unf_flag,
   input  logic                      flag_clr
);

   logic                     en;
   logic                     xfer;
   logic [FP_W-1:0]          comp_in   [2];
   fp_cls_e                  cls_now   [2];
   logic signed [EXP_W+1:0]  e_sum_now [2];
   logic [FP_W-1:0]          result    [2];
   logic [1:0]               ovf_now;
   logic [1:0]               unf_now;

   logic                     s1_valid;
   logic                     s1_sign   [2];
   logic [EXP_W-1:0]         s1_exp    [2];
   logic [MAN_W-1:0]         s1_man    [2];
   fp_cls_e                  s1_cls    [2];
   logic signed [EXP_W+1:0]  s1_e_sum  [2];
   logic                     s2_ovf;
   logic                     s2_unf;

   assign en         = ~out_valid | out_ready;
   assign in_ready   = en;
   assign xfer       = out_valid & out_ready;
   assign comp_in[0] = in_re;
   assign comp_in[1] = in_img;

   for (genvar c = 0; c < 2; c++) begin : g_lane
      fp_pow2_lane #(
         .EXP_W   (EXP_W),
         .MAN_W   (MAN_W),
         .SHIFT_W (SHIFT_W)
      ) u_lane (
         .exp_field (comp_in[c][FP_W-2:MAN_W]),
         .shift     (in_shift),
         .cls       (cls_now[c]),
         .e_sum     (e_sum_now[c]),
         .reg_sign  (s1_sign[c]),
         .reg_exp   (s1_exp[c]),
         .reg_man   (s1_man[c]),
         .reg_cls   (s1_cls[c]),
         .reg_e_sum (s1_e_sum[c]),
         .result    (result[c]),
         .ovf       (ovf_now[c]),
         .unf       (unf_now[c])
      );
   end

   // Both stages advance together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_img   <= '0;
         s2_ovf    <= 1'b0;
         s2_unf    <= 1'b0;
         for (int c = 0; c < 2; c++) begin
            s1_sign[c]  <= 1'b0;
            s1_exp[c]   <= '0;
            s1_man[c]   <= '0;
            s1_cls[c]   <= CLS_ZERO;
            s1_e_sum[c] <= '0;
         end
      end else if (en) begin
         s1_valid  <= in_valid;
         out_valid <= s1_valid;
         out_re    <= result[0];
         out_img   <= result[1];
         s2_ovf    <= s1_valid & (|ovf_now);
         s2_unf    <= s1_valid & (|unf_now);
         for (int c = 0; c < 2; c++) begin
            s1_sign[c]  <= comp_in[c][FP_W-1];
            s1_exp[c]   <= comp_in[c][FP_W-2:MAN_W];
            s1_man[c]   <= comp_in[c][MAN_W-1:0];
            s1_cls[c]   <= cls_now[c];
            s1_e_sum[c] <= e_sum_now[c];
         end
      end
   end

   // A flag event on the output transfer cycle beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_flag <= 1'b0;
         unf_flag <= 1'b0;
      end else begin
         ovf_flag <= (xfer & s2_ovf) | (ovf_flag & ~flag_clr);
         unf_flag <= (xfer & s2_unf) | (unf_flag & ~flag_clr);
      end
   end

endmodule

// File: tb/tb_cplx_fp_pow2_scale.sv
// Directed self-checking bench for cplx_fp_pow2_scale: special classes, flag
// behaviour, back-pressure streaming and mid-stream reset.
module tb_cplx_fp_pow2_scale;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_re;
   logic [31:0] in_img;
   logic [4:0]  in_shift;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_re;
   logic [31:0] out_img;
   logic        ovf_flag;
   logic        unf_flag;
   logic        flag_clr;

   int errors = 0;
   int checks = 0;

   cplx_fp_pow2_scale dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_re     (in_re),
      .in_img    (in_img),
      .in_shift  (in_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_img   (out_img),
      .ovf_flag  (ovf_flag),
      .unf_flag  (unf_flag),
      .flag_clr  (flag_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // One sample in, outputs visible at the return negedge (two clocks later).
   task automatic applyStimulus(input logic [31:0] re, input logic [31:0] img, input logic [4:0] sh);
      @(negedge clk);
      in_re    = re;
      in_img   = img;
      in_shift = sh;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("latency_early", {31'b0, out_valid}, 32'd0);
      @(negedge clk);
   endtask

   task automatic checkSample(input string tag, input logic [31:0] exp_re, input logic [31:0] exp_img);
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({tag, "_re"}, out_re, exp_re);
      checkOutput({tag, "_img"}, out_img, exp_img);
   endtask

   task automatic checkFlags(input string tag, input logic ovf, input logic unf);
      checkOutput({tag, "_ovf"}, {31'b0, ovf_flag}, {31'b0, ovf});
      checkOutput({tag, "_unf"}, {31'b0, unf_flag}, {31'b0, unf});
   endtask

   function automatic logic [31:0] streamIn(input int i, input bit img);
      return img ? {1'b1, 8'(50 + i), 23'(i * 5)} : {1'b0, 8'(100 + i), 23'(i * 3 + 1)};
   endfunction

   function automatic logic [31:0] streamExp(input int i, input bit img);
      return img ? {1'b1, 8'(51 + i), 23'(i * 5)} : {1'b0, 8'(101 + i), 23'(i * 3 + 1)};
   endfunction

   initial begin
      int in_idx;
      int out_idx;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_re     = '0;
      in_img    = '0;
      in_shift  = '0;
      out_ready = 1'b1;
      flag_clr  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("rst_re", out_re, 32'h0);
      checkOutput("rst_img", out_img, 32'h0);
      checkFlags("rst", 1'b0, 1'b0);
      checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;

      applyStimulus(32'h3F800000, 32'hC0000000, 5'h1C);
      checkSample("scale_m4", 32'h3D800000, 32'hBE000000);
      @(negedge clk);
      checkFlags("scale_m4", 1'b0, 1'b0);

      applyStimulus(32'h7F000000, 32'h00000000, 5'h02);
      checkSample("ovf", 32'h7F800000, 32'h00000000);
      @(negedge clk);
      checkFlags("ovf", 1'b1, 1'b0);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;
      checkFlags("ovf_clr", 1'b0, 1'b0);

      applyStimulus(32'h80000000, 32'h00800000, 5'h1F);
      checkSample("unf", 32'h80000000, 32'h00000000);
      @(negedge clk);
      checkFlags("unf", 1'b0, 1'b1);

      flag_clr = 1'b1;
      applyStimulus(32'h7F000000, 32'h3F800000, 5'h02);
      checkSample("clr_race", 32'h7F800000, 32'h40800000);
      @(negedge clk);
      flag_clr = 1'b0;
      checkFlags("clr_race", 1'b1, 1'b0);
      flag_clr = 1'b1;
      @(negedge clk);
      flag_clr = 1'b0;

      applyStimulus(32'h7FC00001, 32'hFF800000, 5'h07);
      checkSample("special", 32'h7FC00001, 32'hFF800000);
      @(negedge clk);
      checkFlags("special", 1'b0, 1'b0);

      applyStimulus(32'h00000001, 32'h807FFFFF, 5'h03);
      checkSample("denorm", 32'h00000000, 32'h80000000);
      @(negedge clk);
      checkFlags("denorm", 1'b0, 1'b0);

      applyStimulus(32'h12345678, 32'hC1234567, 5'h00);
      checkSample("passthru", 32'h12345678, 32'hC1234567);

      applyStimulus(32'h7E800000, 32'h00800000, 5'h01);
      checkSample("edge_up", 32'h7F000000, 32'h01000000);

      applyStimulus(32'h01000000, 32'h7F7FFFFF, 5'h1F);
      checkSample("edge_dn", 32'h00800000, 32'h7EFFFFFF);
      @(negedge clk);
      checkFlags("edges", 1'b0, 1'b0);

      applyStimulus(32'h3F800000, 32'h08000000, 5'h10);
      checkSample("shift_m16", 32'h37800000, 32'h00000000);
      @(negedge clk);
      checkFlags("shift_m16", 1'b0, 1'b1);

      // Stream eight samples with a three-cycle output stall in the middle.
      in_idx  = 0;
      out_idx = 0;
      for (int cyc = 0; cyc < 40 && out_idx < 8; cyc++) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc < 7);
         in_valid  = (in_idx < 8);
         in_re     = streamIn(in_idx, 1'b0);
         in_img    = streamIn(in_idx, 1'b1);
         in_shift  = 5'h01;
         #1;
         if (!out_ready) begin
            checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_re_held", out_re, streamExp(out_idx, 1'b0));
            checkOutput("stall_img_held", out_img, streamExp(out_idx, 1'b1));
         end
         if (out_valid && out_ready) begin
            checkOutput("stream_re", out_re, streamExp(out_idx, 1'b0));
            checkOutput("stream_img", out_img, streamExp(out_idx, 1'b1));
            out_idx++;
         end
         if (in_valid && in_ready) begin
            in_idx++;
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkOutput("stream_count", 32'(out_idx), 32'd8);
      checkOutput("stream_no_dup", {31'b0, out_valid}, 32'd0);

      // Reset with two samples in flight; the unf flag is still set from earlier.
      checkFlags("pre_rst", 1'b0, 1'b1);
      @(negedge clk);
      in_re    = 32'h7F000000;
      in_img   = 32'h00000000;
      in_shift = 5'h02;
      in_valid = 1'b1;
      @(negedge clk);
      in_re    = 32'h3F800000;
      in_img   = 32'h3F800000;
      in_shift = 5'h01;
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("midrst_re", out_re, 32'h0);
      checkFlags("midrst", 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("midrst_no_ghost", {31'b0, out_valid}, 32'd0);

      applyStimulus(32'h40000000, 32'hC0400000, 5'h01);
      checkSample("post_rst", 32'h40800000, 32'hC0C00000);
      @(negedge clk);
      checkFlags("post_rst", 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
